// File: rtl/dot_mem_sequencer.sv
// Control sequencer for a bank of operand SRAMs plus one result SRAM: clear, handshaked load,
// and a multi-vector compute pass feeding a fixed-latency MAC pipeline. All outputs are registered.
module dot_mem_sequencer #(
  parameter int Addr_Width           = 5,
  parameter int Nums_SRAM_In         = 2,
  parameter int Nums_SRAM            = Nums_SRAM_In + 1,
  parameter int Nums_Data_in_bits    = 4,
  parameter int Vec_Count            = 2,
  parameter int Nums_Pipeline_Stages = 4
) (
  input  logic                            clk,
  input  logic                            Mem_reset,
  input  logic                            Comp_reset,
  input  logic                            clear_start,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            Acc_Clear,
  output logic [Nums_SRAM-1:0]            Mem_Clear,
  output logic [Nums_SRAM-1:0]            En_Chip_Select,
  output logic [Nums_SRAM-1:0]            En_Write,
  output logic [Nums_SRAM-1:0]            En_Read,
  output logic [Nums_SRAM*Addr_Width-1:0] Addr_Read,
  output logic [Nums_SRAM*Addr_Width-1:0] Addr_Write,
  output logic [2:0]                      dbg_state
);

  localparam int AW  = Addr_Width;
  localparam int NDB = Nums_Data_in_bits;
  localparam int NPS = Nums_Pipeline_Stages;
  localparam int SW  = $clog2(Nums_SRAM_In + 1);
  localparam int NumsData = 1 << Nums_Data_in_bits;
  localparam logic [AW-1:0] K_LAST = AW'(Vec_Count * NumsData - 1);
  localparam logic [SW-1:0] S_END  = SW'(Nums_SRAM_In);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COMPUTE, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           k_q, k_d, a_q, a_d, v_q, v_d;
  logic [SW-1:0]           s_q, s_d;
  logic [NPS-1:0]          pipe_q, pipe_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    load_ready_q, load_ready_d, acc_clear_q, acc_clear_d;
  logic [Nums_SRAM-1:0]    mem_clear_q, mem_clear_d, cs_q, cs_d, we_q, we_d, re_q, re_d;
  logic [Nums_SRAM*AW-1:0] raddr_q, raddr_d, waddr_q, waddr_d;

  logic                    do_read, do_load;
  logic [AW-1:0]           rd_k, ld_a;
  logic [SW-1:0]           ld_s;

  // Load handshake: a beat transfers in any LOAD cycle where load_valid is high; load_ready is
  // the registered echo of that acceptance and is shown in the cycle the beat's write is issued.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    a_d          = a_q;
    s_d          = s_q;
    v_d          = v_q;
    pipe_d       = pipe_q;
    load_ready_d = 1'b0;
    acc_clear_d  = 1'b0;
    mem_clear_d  = '0;
    cs_d         = '0;
    we_d         = '0;
    re_d         = '0;
    raddr_d      = '0;
    waddr_d      = '0;
    do_read      = 1'b0;
    rd_k         = '0;
    do_load      = 1'b0;
    ld_s         = '0;
    ld_a         = '0;

    if (Comp_reset) begin
      state_d = IDLE;
      k_d     = '0;
      a_d     = '0;
      s_d     = '0;
      v_d     = '0;
      pipe_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_d     = CLEAR;
            mem_clear_d = '1;
            cs_d        = '1;
          end else if (load_valid) begin
            state_d = LOAD;
            do_load = 1'b1;
          end else if (start) begin
            state_d = COMPUTE;
            do_read = 1'b1;
            v_d     = '0;
          end
        end
        CLEAR: state_d = IDLE;
        LOAD: begin
          if (s_q == S_END) begin
            state_d = IDLE;
            s_d     = '0;
            a_d     = '0;
          end else if (load_valid) begin
            do_load = 1'b1;
            ld_s    = s_q;
            ld_a    = a_q;
          end
        end
        COMPUTE: begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
          end else begin
            do_read = 1'b1;
            rd_k    = k_q + AW'(1);
          end
        end
        DRAIN: if (pipe_q == '0) state_d = DONE;
        DONE: begin
          state_d = IDLE;
          k_d     = '0;
          v_d     = '0;
        end
        default: state_d = IDLE;
      endcase

      if (do_load) begin
        load_ready_d                 = 1'b1;
        we_d[ld_s]                   = 1'b1;
        cs_d[ld_s]                   = 1'b1;
        waddr_d[int'(ld_s)*AW +: AW] = ld_a;
        if (ld_a == K_LAST) begin
          a_d = '0;
          s_d = ld_s + SW'(1);
        end else begin
          a_d = ld_a + AW'(1);
        end
      end

      if (do_read) begin
        k_d         = rd_k;
        acc_clear_d = (rd_k[NDB-1:0] == '0);
        for (int i = 0; i < Nums_SRAM_In; i++) begin
          re_d[i]              = 1'b1;
          cs_d[i]              = 1'b1;
          raddr_d[i*AW +: AW]  = rd_k;
        end
      end

      // The oldest flag marks a vector whose final product leaves the pipeline next cycle.
      pipe_d = (pipe_q << 1) | NPS'(do_read & (&rd_k[NDB-1:0]));
      if (pipe_q[NPS-1]) begin
        we_d[Nums_SRAM-1]                 = 1'b1;
        cs_d[Nums_SRAM-1]                 = 1'b1;
        waddr_d[(Nums_SRAM-1)*AW +: AW]   = v_q;
        v_d                               = v_q + AW'(1);
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge Mem_reset) begin
    if (Mem_reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      a_q          <= '0;
      s_q          <= '0;
      v_q          <= '0;
      pipe_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b0;
      acc_clear_q  <= 1'b0;
      mem_clear_q  <= '0;
      cs_q         <= '0;
      we_q         <= '0;
      re_q         <= '0;
      raddr_q      <= '0;
      waddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      a_q          <= a_d;
      s_q          <= s_d;
      v_q          <= v_d;
      pipe_q       <= pipe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
      acc_clear_q  <= acc_clear_d;
      mem_clear_q  <= mem_clear_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      re_q         <= re_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
    end
  end

  assign load_ready     = load_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign Acc_Clear      = acc_clear_q;
  assign Mem_Clear      = mem_clear_q;
  assign En_Chip_Select = cs_q;
  assign En_Write       = we_q;
  assign En_Read        = re_q;
  assign Addr_Read      = raddr_q;
  assign Addr_Write     = waddr_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_dot_mem_sequencer.sv
// Directed bench for dot_mem_sequencer at default parameters: reset, clear, load (continuous and
// gapped), compute, abort and ignored inputs, with expectations worked out from the cycle timing.
module tb_dot_mem_sequencer;

  logic        clk = 1'b0;
  logic        Mem_reset, Comp_reset, clear_start, load_valid, start;
  logic        load_ready, busy, done, Acc_Clear;
  logic [2:0]  Mem_Clear, En_Chip_Select, En_Write, En_Read;
  logic [14:0] Addr_Read, Addr_Write;
  logic [2:0]  dbg_state;
  logic [45:0] outs;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [6:0] exp_q[$];

  dot_mem_sequencer dut (
    .clk(clk), .Mem_reset(Mem_reset), .Comp_reset(Comp_reset), .clear_start(clear_start),
    .load_valid(load_valid), .load_ready(load_ready), .start(start), .busy(busy), .done(done),
    .Acc_Clear(Acc_Clear), .Mem_Clear(Mem_Clear), .En_Chip_Select(En_Chip_Select),
    .En_Write(En_Write), .En_Read(En_Read), .Addr_Read(Addr_Read), .Addr_Write(Addr_Write),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign outs = {busy, done, load_ready, Acc_Clear, Mem_Clear, En_Chip_Select, En_Write,
                 En_Read, Addr_Read, Addr_Write};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives 64 load beats, one every `step` cycles, with a stray start pulse mid-load.
  task automatic run_load(input int step, input string tag);
    logic [6:0]  e;
    logic [24:0] exp;
    logic        lv;
    exp_q.delete();
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 32; a++) exp_q.push_back({2'(s), 5'(a)});
    for (int c = 0; c <= 64 * step; c++) begin
      lv = (c < 64 * step) && (c % step == 0);
      load_valid = lv;
      start = (c == 10);
      tick();
      exp = '0;
      if (lv) begin
        e   = exp_q.pop_front();
        exp = {1'b1, 3'b001 << e[6:5], 3'b001 << e[6:5], 15'(e[4:0]) << (5 * e[6:5]), 3'b000};
      end
      chk(tag, {load_ready, En_Write, En_Chip_Select, Addr_Write, En_Read}, exp);
    end
    load_valid = 1'b0;
    start = 1'b0;
    chk({tag, "_end"}, outs, '0);
  endtask

  // Runs one compute pass; abort_cyc > 0 pulses Comp_reset in that cycle.
  task automatic run_compute(input int abort_cyc, input string tag);
    logic        live, e_busy, e_done, e_acc;
    logic [2:0]  e_cs, e_we, e_re;
    logic [14:0] e_ra, e_wa;
    int k;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 38; cyc++) begin
      live   = (abort_cyc == 0) || (cyc <= abort_cyc);
      e_busy = live && (cyc <= 37);
      e_done = live && (cyc == 37);
      e_acc  = 1'b0;
      e_re   = '0;
      e_ra   = '0;
      e_we   = '0;
      e_wa   = '0;
      if (live && cyc <= 32) begin
        k     = cyc - 1;
        e_re  = 3'b011;
        e_ra  = {5'd0, 5'(k), 5'(k)};
        e_acc = (k % 16 == 0);
      end
      if (live && cyc == 20) begin e_we = 3'b100; e_wa = {5'd0, 10'd0}; end
      if (live && cyc == 36) begin e_we = 3'b100; e_wa = {5'd1, 10'd0}; end
      e_cs = e_re | e_we;
      chk($sformatf("%s_c%0d", tag, cyc),
          {busy, done, Acc_Clear, Mem_Clear, En_Chip_Select, En_Write, En_Read, Addr_Read, Addr_Write},
          {e_busy, e_done, e_acc, 3'b000, e_cs, e_we, e_re, e_ra, e_wa});
      Comp_reset  = (cyc == abort_cyc);
      clear_start = (abort_cyc == 0) && (cyc == 5);
      tick();
    end
    Comp_reset  = 1'b0;
    clear_start = 1'b0;
  endtask

  initial begin
    Mem_reset = 1'b1; Comp_reset = 1'b0; clear_start = 1'b0; load_valid = 1'b0; start = 1'b0;
    tick();
    chk("rst_outs", outs, '0);
    chk("rst_state", dbg_state, 3'd0);
    Mem_reset = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);

    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("clear_cycle", {busy, Mem_Clear, En_Chip_Select, En_Write, En_Read}, {1'b1, 3'b111, 3'b111, 6'b0});
    tick();
    chk("clear_after", outs, '0);

    run_load(1, "load_cont");
    run_load(2, "load_gap");

    run_compute(0, "comp");
    run_compute(18, "abort");
    run_compute(0, "comp_again");

    load_valid = 1'b1;
    repeat (5) tick();
    #2 Mem_reset = 1'b1;
    #1;
    chk("async_rst_outs", outs, '0);
    chk("async_rst_state", dbg_state, 3'd0);
    load_valid = 1'b0;
    tick();
    Mem_reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    run_load(1, "load_post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
